// File: rtl/calc_cmd_if.sv
// calc_cmd_if: token, calculator command/result and status bundle for calc_cmd_issuer
//   in_valid, in_token, in_ready                    : token handshake into the issue FIFO
//   push_num, shift_and_push, do_other_op, calc_reset: single-cycle command strobes to the calculator
//   input_number, other_op_code                     : command payloads, held until the next issue
//   calc_error, calc_out, calc_size                 : live calculator outputs
//   result_valid, result_num, result_error,
//   result_size, err_count, idle                    : sampled results and status
interface calc_cmd_if;
  logic in_valid;
  logic [9:0] in_token;
  logic in_ready;
  logic push_num;
  logic shift_and_push;
  logic do_other_op;
  logic calc_reset;
  logic [7:0] input_number;
  logic [2:0] other_op_code;
  logic calc_error;
  logic [31:0] calc_out;
  logic [9:0] calc_size;
  logic result_valid;
  logic [31:0] result_num;
  logic result_error;
  logic [9:0] result_size;
  logic [7:0] err_count;
  logic idle;
  modport master (
    output in_valid, in_token, calc_error, calc_out, calc_size,
    input in_ready, push_num, shift_and_push, do_other_op, calc_reset, input_number, other_op_code,
    input result_valid, result_num, result_error, result_size, err_count, idle
  );
  modport slave (
    input in_valid, in_token, calc_error, calc_out, calc_size,
    output in_ready, push_num, shift_and_push, do_other_op, calc_reset, input_number, other_op_code,
    output result_valid, result_num, result_error, result_size, err_count, idle
  );
endinterface

// File: rtl/calc_cmd_issuer.sv
// calc_cmd_issuer: buffers 10-bit tokens and issues them one at a time as calculator commands, sampling the result
//   clk, reset : clock, synchronous active-high reset
//   bus        : calc_cmd_if.slave (token handshake, command strobes/payloads, calculator outputs, results, status)
//   BUSY_CYCLES: cycles from a command strobe to result sampling (8-15)
//   FIFO_DEPTH : token buffer entries (power of two, 2-16)
module calc_cmd_issuer #(
  parameter int BUSY_CYCLES = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  calc_cmd_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, SAMPLE} state_t;
  state_t state, state_n;
  logic [9:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [9:0] tok;
  logic [3:0] cnt, cnt_n;
  logic empty, full, pop, push, issuing;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign pop = state == IDLE && !empty;
  // a pop frees a slot on the same edge, so a full FIFO still accepts while it is drained
  assign bus.in_ready = !reset && (!full || pop);
  assign push = bus.in_valid && bus.in_ready;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= bus.in_token;
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      tok <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (pop) tok <= mem[rd_ptr[AW-1:0]];
    end
  // the transition to SAMPLE happens on the edge where the count reaches 0,
  // giving BUSY_CYCLES-1 WAIT cycles for commands and 1 for clear
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: state_n = empty ? IDLE : ISSUE;
      ISSUE: begin
        state_n = WAIT;
        cnt_n = tok[9:8] == 2'b11 ? 4'd1 : 4'(BUSY_CYCLES - 1);
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        state_n = cnt <= 4'd1 ? SAMPLE : WAIT;
      end
      SAMPLE: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      bus.result_valid <= 1'b0;
      bus.result_num <= '0;
      bus.result_error <= 1'b0;
      bus.result_size <= '0;
      bus.err_count <= '0;
    end else begin
      bus.result_valid <= state == SAMPLE;
      if (state == SAMPLE) begin
        bus.result_num <= bus.calc_out;
        bus.result_error <= bus.calc_error;
        bus.result_size <= bus.calc_size;
        if (bus.calc_error && bus.err_count != 8'hff) bus.err_count <= bus.err_count + 8'd1;
      end
    end
  assign issuing = state == ISSUE && !reset;
  assign bus.push_num = issuing && tok[9:8] == 2'b00;
  assign bus.shift_and_push = issuing && tok[9:8] == 2'b01;
  assign bus.do_other_op = issuing && tok[9:8] == 2'b10;
  assign bus.calc_reset = reset || (issuing && tok[9:8] == 2'b11);
  assign bus.input_number = tok[7:0];
  assign bus.other_op_code = tok[2:0];
  assign bus.idle = !reset && state == IDLE && empty;
endmodule

// File: tb/tb_calc_cmd_issuer.sv
// tb_calc_cmd_issuer: table, directed and random checks of calc_cmd_issuer driving a stack-calculator model
module tb_calc_cmd_issuer;
  localparam int BC = 8;
  localparam int FD = 4;
  typedef struct packed {
    logic [15:0][31:0] v;
    logic [9:0] n;
    logic e;
  } calc_t;
  typedef struct packed {
    logic [31:0] num;
    logic err;
    logic [9:0] size;
    logic [7:0] ec;
  } res_t;
  typedef struct packed {
    logic [9:0] tok;
    logic [31:0] num;
    logic err;
    logic [9:0] size;
    logic [7:0] ec;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  calc_cmd_if bus();
  calc_cmd_issuer #(.BUSY_CYCLES(BC), .FIFO_DEPTH(FD)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int vec = 0;
  int bad = 0;
  int cyc = 0;
  int res_cnt = 0;
  int iss_t[$];
  logic [7:0] iss_p[$];
  logic [9:0] sb[$];
  res_t ex[$];
  calc_t env = '0;
  calc_t rc = '0;
  logic [7:0] ref_err = 0;
  function automatic logic [31:0] top(calc_t c);
    return c.n == 10'd0 ? 32'd0 : c.v[4'(c.n - 10'd1)];
  endfunction
  // stack calculator: push, shift_push (top<<16 | n), op 0 add, 1 sub, 2 drop, others nop, clear
  function automatic calc_t step(calc_t c, logic [9:0] t);
    calc_t r;
    logic [3:0] a, b;
    r = c;
    r.e = 1'b0;
    a = 4'(c.n - 10'd1);
    b = 4'(c.n - 10'd2);
    case (t[9:8])
      2'd0: if (c.n == 10'd16) r.e = 1'b1; else begin r.v[4'(c.n)] = {24'd0, t[7:0]}; r.n = c.n + 10'd1; end
      2'd1: if (c.n == 10'd0) r.e = 1'b1; else r.v[a] = {c.v[a][15:0], 8'd0, t[7:0]};
      2'd2:
        case (t[2:0])
          3'd0, 3'd1: if (c.n < 10'd2) r.e = 1'b1; else begin r.v[b] = t[0] ? c.v[b] - c.v[a] : c.v[b] + c.v[a]; r.n = c.n - 10'd1; end
          3'd2: if (c.n == 10'd0) r.e = 1'b1; else r.n = c.n - 10'd1;
          default: ;
        endcase
      default: r = '0;
    endcase
    return r;
  endfunction
  always @(posedge clk)
    env <= bus.calc_reset ? '0 :
           bus.push_num ? step(env, {2'd0, bus.input_number}) :
           bus.shift_and_push ? step(env, {2'd1, bus.input_number}) :
           bus.do_other_op ? step(env, {2'd2, 5'd0, bus.other_op_code}) : env;
  assign bus.calc_out = top(env);
  assign bus.calc_error = env.e;
  assign bus.calc_size = env.n;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic expired(input string name);
    vec++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask
  // reference: tokens leave in arrival order, each produces the calculator state after it
  initial begin
    int s, k, last_t, last_k, prev_s;
    logic [9:0] t;
    res_t r;
    last_t = -1;
    last_k = 0;
    prev_s = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        sb.delete();
        ex.delete();
        rc = '0;
        ref_err = 0;
        last_t = -1;
        prev_s = 0;
      end else begin
        s = int'(bus.push_num) + int'(bus.shift_and_push) + int'(bus.do_other_op) + int'(bus.calc_reset);
        if (s != 0) begin
          check("strobe_onehot", s, 1);
          check("strobe_one_cycle", prev_s, 0);
          k = bus.push_num ? 0 : bus.shift_and_push ? 1 : bus.do_other_op ? 2 : 3;
          if (last_t >= 0) check("issue_spacing_min", 32'((cyc - last_t) >= (last_k == 3 ? 4 : BC + 2)), 1);
          last_t = cyc;
          last_k = k;
          iss_t.push_back(cyc);
          iss_p.push_back(bus.input_number);
          if (sb.size() == 0) expired("issue_without_token");
          else begin
            t = sb.pop_front();
            check("issue_kind", k, 32'(t[9:8]));
            if (k < 2) check("issue_number", bus.input_number, t[7:0]);
            if (k == 2) check("issue_opcode", bus.other_op_code, t[2:0]);
            rc = step(rc, t);
            if (rc.e && ref_err != 8'hff) ref_err = ref_err + 8'd1;
            ex.push_back({top(rc), rc.e, rc.n, ref_err});
          end
        end
        prev_s = s;
        if (bus.result_valid) begin
          res_cnt++;
          if (ex.size() == 0) expired("result_without_issue");
          else begin
            r = ex.pop_front();
            check("ref_result_num", bus.result_num, r.num);
            check("ref_result_error", bus.result_error, r.err);
            check("ref_result_size", bus.result_size, r.size);
            check("ref_err_count", bus.err_count, r.ec);
          end
        end
        if (sb.size() < FD) check("in_ready_free_slot", bus.in_ready, 1);
        if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_token);
      end
    end
  end
  task automatic reset_dut();
    @(posedge clk);
    #1 reset = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask
  task automatic send(input logic [9:0] t);
    bit ok;
    ok = 0;
    @(posedge clk);
    #1 bus.in_valid = 1'b1;
    bus.in_token = t;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
    end
    if (!ok) expired("send");
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic wait_res(input string name, output bit ok);
    int r0;
    r0 = res_cnt;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      #1 ok = res_cnt != r0;
    end
    if (!ok) expired(name);
  endtask
  task automatic drain(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      #1 ok = bus.idle;
    end
    if (!ok) expired(name);
    check("drain_no_pending_result", ex.size(), 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vec_t tbl[15];
    bit ok;
    int first_stall, acc, r0;
    logic [9:0] t;
    tbl[0]  = '{10'h005, 32'd5, 1'b0, 10'd1, 8'd0};
    tbl[1]  = '{10'h007, 32'd7, 1'b0, 10'd2, 8'd0};
    tbl[2]  = '{10'h200, 32'd12, 1'b0, 10'd1, 8'd0};
    tbl[3]  = '{10'h300, 32'd0, 1'b0, 10'd0, 8'd0};
    tbl[4]  = '{10'h001, 32'd1, 1'b0, 10'd1, 8'd0};
    tbl[5]  = '{10'h134, 32'h10034, 1'b0, 10'd1, 8'd0};
    tbl[6]  = '{10'h300, 32'd0, 1'b0, 10'd0, 8'd0};
    tbl[7]  = '{10'h200, 32'd0, 1'b1, 10'd0, 8'd1};
    tbl[8]  = '{10'h009, 32'd9, 1'b0, 10'd1, 8'd1};
    tbl[9]  = '{10'h300, 32'd0, 1'b0, 10'd0, 8'd1};
    tbl[10] = '{10'h00a, 32'd10, 1'b0, 10'd1, 8'd1};
    tbl[11] = '{10'h003, 32'd3, 1'b0, 10'd2, 8'd1};
    tbl[12] = '{10'h201, 32'd7, 1'b0, 10'd1, 8'd1};
    tbl[13] = '{10'h0c8, 32'd200, 1'b0, 10'd2, 8'd1};
    tbl[14] = '{10'h202, 32'd7, 1'b0, 10'd1, 8'd1};
    bus.in_valid = 1'b0;
    bus.in_token = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 check("rst_in_ready", bus.in_ready, 0);
    check("rst_idle", bus.idle, 0);
    check("rst_calc_reset", bus.calc_reset, 1);
    check("rst_strobes", {bus.push_num, bus.shift_and_push, bus.do_other_op}, 0);
    check("rst_result_valid", bus.result_valid, 0);
    check("rst_result_num", bus.result_num, 0);
    check("rst_result_size", bus.result_size, 0);
    check("rst_result_error", bus.result_error, 0);
    check("rst_err_count", bus.err_count, 0);
    check("rst_payloads", {bus.input_number, bus.other_op_code}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1 check("rel_in_ready", bus.in_ready, 1);
    check("rel_idle", bus.idle, 1);
    check("rel_calc_reset", bus.calc_reset, 0);
    for (int i = 0; i < 15; i++) begin
      send(tbl[i].tok);
      wait_res("tbl_result_wait", ok);
      if (ok) begin
        check("tbl_result_num", bus.result_num, tbl[i].num);
        check("tbl_result_error", bus.result_error, tbl[i].err);
        check("tbl_result_size", bus.result_size, tbl[i].size);
        check("tbl_err_count", bus.err_count, tbl[i].ec);
      end
    end
    drain("tbl_drain");
    reset_dut();
    iss_t.delete();
    iss_p.delete();
    first_stall = -1;
    acc = 0;
    @(posedge clk);
    #1 bus.in_valid = 1'b1;
    bus.in_token = 10'h001;
    for (int i = 0; i < 200 && acc < 6; i++) begin
      @(negedge clk);
      if (bus.in_ready) acc++;
      else if (first_stall < 0) first_stall = acc;
      @(posedge clk);
      #1 bus.in_token = {2'd0, 8'(acc + 1)};
    end
    bus.in_valid = 1'b0;
    check("b2b_accepts_before_stall", first_stall, 5);
    check("b2b_all_accepted", acc, 6);
    for (int i = 0; i < 100 && iss_t.size() < 6; i++) @(negedge clk);
    if (iss_t.size() < 6) expired("b2b_issues");
    else for (int i = 1; i < 6; i++) begin
      check("b2b_issue_spacing", iss_t[i] - iss_t[i-1], BC + 2);
      check("b2b_issue_order", iss_p[i], 8'(i + 1));
    end
    drain("b2b_drain");
    reset_dut();
    iss_t.delete();
    send(10'h042);
    for (int i = 0; i < 40 && iss_t.size() == 0; i++) @(negedge clk);
    if (iss_t.size() == 0) expired("abort_issue");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    r0 = res_cnt;
    @(negedge clk);
    #1 check("abort_idle", bus.idle, 1);
    check("abort_result_num", bus.result_num, 0);
    check("abort_result_size", bus.result_size, 0);
    check("abort_input_number", bus.input_number, 0);
    repeat (20) @(negedge clk);
    check("abort_no_result", res_cnt - r0, 0);
    reset_dut();
    r0 = res_cnt;
    @(posedge clk);
    #1 bus.in_valid = 1'b1;
    bus.in_token = 10'h200;
    for (int i = 0; i < 4000 && res_cnt - r0 < 258; i++) @(negedge clk);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    if (res_cnt - r0 < 258) expired("sat_results");
    drain("sat_drain");
    check("sat_err_count", bus.err_count, 8'hff);
    reset_dut();
    for (int i = 0; i < 300; i++) begin
      k_sel: begin
        int r;
        r = int'($urandom_range(0, 9));
        t[9:8] = r < 4 ? 2'd0 : r < 6 ? 2'd1 : r < 9 ? 2'd2 : 2'd3;
        t[7:0] = 8'($urandom);
      end
      send(t);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 15)) @(posedge clk);
    end
    drain("rand_drain");
    check("rand_fifo_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/calc_cmd_issuer.md
CALC_CMD_ISSUER -- requirements
Module: calc_cmd_issuer

Interface
REQ-001 Parameter BUSY_CYCLES, default 8: cycles waited after a command pulse before results are sampled; legal range 8-15.
REQ-002 Parameter FIFO_DEPTH, default 4: token buffer entries; power of two, 2-16.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 in_valid  input  1  a token is offered on in_token.
REQ-006 in_token  input  10  [9:8] kind (00 push, 01 shift_push, 10 op, 11 clear); [7:0] payload.
REQ-007 in_ready  output  1  the FIFO can accept a token this cycle.
REQ-008 push_num, shift_and_push, do_other_op  output  1 each  single-cycle command strobes to the calculator.
REQ-009 calc_reset  output  1  calculator reset strobe.
REQ-010 input_number  output  8  payload for push and shift_push.
REQ-011 other_op_code  output  3  payload[2:0] for op tokens.
REQ-012 calc_error  input  1  calculator error_bit.
REQ-013 calc_out  input  32  calculator out_num.
REQ-014 calc_size  input  10  calculator stack_size.
REQ-015 result_valid  output  1  one-cycle strobe: the result_* outputs were updated this cycle.
REQ-016 result_num, result_error, result_size  output  32/1/10  sampled calculator outputs, held until the next update.
REQ-017 err_count  output  8  count of tokens that ended with calc_error=1; saturates at 255.
REQ-018 idle  output  1  high when the FSM is in IDLE and the FIFO is empty.

Function
REQ-019 A token shall be accepted into the FIFO on a cycle where in_valid and in_ready are both high; in_ready = FIFO not full.
REQ-020 A simultaneous accept and pop while the FIFO is full shall be permitted, leaving the occupancy unchanged; tokens shall be issued strictly in arrival order.
REQ-021 FSM states: IDLE, ISSUE, WAIT, SAMPLE.
REQ-022 IDLE -> ISSUE when the FIFO is non-empty; the token is popped and registered on that edge.
REQ-023 ISSUE lasts exactly 1 cycle and asserts exactly one strobe selected by kind: 00 push_num, 01 shift_and_push, 10 do_other_op, 11 calc_reset.
REQ-024 input_number and other_op_code shall be valid during ISSUE and held until the next ISSUE.
REQ-025 ISSUE -> WAIT; the 4-bit counter loads BUSY_CYCLES-1 for command kinds, or 1 for clear, and decrements each cycle; WAIT -> SAMPLE at count 0.
REQ-026 SAMPLE lasts 1 cycle: it registers calc_out, calc_error and calc_size into result_*, pulses result_valid, and increments err_count if calc_error=1 (saturating); SAMPLE -> IDLE.
REQ-027 The minimum token-to-token issue spacing shall be BUSY_CYCLES+2 cycles for commands and 4 cycles for clear.
REQ-028 All strobes shall be 0 outside ISSUE, and no two strobes shall ever be high in the same cycle.
REQ-029 Tokens arriving during WAIT or SAMPLE shall be buffered and never dropped while in_ready is high.
REQ-030 A clear token shall not reset err_count.

Reset
REQ-031 While reset is high: FIFO emptied; FSM -> IDLE; all strobes 0 except calc_reset=1; result_* = 0; result_valid=0; err_count=0; input_number=0; other_op_code=0; in_ready=0; idle=0.
REQ-032 reset asserted mid-WAIT shall abort the token with no result_valid pulse.
REQ-033 On the first cycle after reset deasserts: in_ready=1, idle=1, calc_reset=0.

Verification
REQ-034 The bench shall pair the block with the calculator model: tokens push 5, push 7, op 000 -> three result_valid pulses; the last has result_num=12, result_size=1, result_error=0.
REQ-035 Tokens push 1, shift_push 0x34 -> result_num=0x10034, result_size=1.
REQ-036 From an empty stack, op 000 -> result_error=1, err_count=1, result_size=0.
REQ-037 Six tokens offered back-to-back with in_valid held high -> in_ready drops after 5 accepts (4 buffered plus 1 popped), no token is lost, and issue spacing is exactly 10 cycles.
REQ-038 push 9, clear -> calc_reset pulses for 1 cycle, result_size=0, err_count unchanged.
REQ-039 reset pulsed 3 cycles after push_num -> no result_valid pulse, result_*=0, idle=1 one cycle after release.
